// File: rtl/wb_reader_pkg.sv
// Shared types for the Wishbone frame reader: FSM states, bus constants and FIFO word layout.
package wb_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RTY
    } state_t;

    localparam logic [3:0]  WB_SEL_ALL = 4'hF;
    localparam int unsigned DATA_W     = 32;

    typedef struct packed {
        logic              sof;
        logic [DATA_W-1:0] data;
    } fifo_word_t;

    localparam int unsigned FIFO_W = $bits(fifo_word_t);

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word is on dout whenever not empty; clr empties it.
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is still accepted when a pop frees a slot the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone classic read master that streams a frame buffer, word by word and wrapping,
// into a local FIFO drained through a valid/ready pixel interface.
module wb_frame_reader
    import wb_reader_pkg::*;
#(
    parameter int unsigned      ADR_W       = 32,
    parameter logic [ADR_W-1:0] BASE_ADR    = '0,
    parameter int unsigned      FRAME_WORDS = 2048,
    parameter int unsigned      ADR_STEP    = 4,
    parameter int unsigned      FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              flush,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [3:0]        wb_sel_o,
    output logic [ADR_W-1:0]  wb_adr_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_sof,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              err_flag
);

    localparam int unsigned IDX_W = $clog2(FRAME_WORDS);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state, state_nxt;
    logic [ADR_W-1:0] adr, adr_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             err_nxt;
    logic             flush_pend, flush_pend_nxt;
    logic             do_flush;
    logic             term_ack, term_err, term_rty;

    logic             fifo_push;
    logic             fifo_clr;
    fifo_word_t       push_word;
    fifo_word_t       head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    // Termination priority: ack over err over rty.
    assign term_ack = wb_ack_i;
    assign term_err = !wb_ack_i && wb_err_i;
    assign term_rty = !wb_ack_i && !wb_err_i && wb_rty_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            adr        <= BASE_ADR;
            idx        <= '0;
            err_flag   <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            adr        <= adr_nxt;
            idx        <= idx_nxt;
            err_flag   <= err_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        adr_nxt        = adr;
        idx_nxt        = idx;
        err_nxt        = err_flag;
        flush_pend_nxt = flush_pend;
        do_flush       = 1'b0;
        fifo_push      = 1'b0;
        push_word.sof  = (idx == '0);
        push_word.data = '0;

        case (state)
            IDLE: begin
                if (flush)                       do_flush  = 1'b1;
                else if (enable && !fifo_full)   state_nxt = REQ;
            end
            REQ: begin
                if (flush) flush_pend_nxt = 1'b1;
                if (term_ack || term_err) begin
                    if (flush || flush_pend) begin
                        do_flush  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fifo_push      = 1'b1;
                        push_word.data = term_ack ? wb_dat_i : '0;
                        if (term_err) err_nxt = 1'b1;
                        if (idx == IDX_W'(FRAME_WORDS - 1)) begin
                            idx_nxt = '0;
                            adr_nxt = BASE_ADR;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                            adr_nxt = adr + ADR_W'(ADR_STEP);
                        end
                        // Stay back-to-back only while a further slot is guaranteed after this push.
                        state_nxt = (enable && fifo_count <= CNT_W'(FIFO_DEPTH - 3)) ? REQ : IDLE;
                    end
                end else if (term_rty) begin
                    if (flush || flush_pend) begin
                        do_flush  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = WAIT_RTY;
                    end
                end
            end
            WAIT_RTY: begin
                if (flush || flush_pend) begin
                    do_flush  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (do_flush) begin
            adr_nxt        = BASE_ADR;
            idx_nxt        = '0;
            err_nxt        = 1'b0;
            flush_pend_nxt = 1'b0;
        end
        fifo_clr = do_flush;
    end

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .din   (push_word),
        .pop   (pix_ready),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign wb_cyc_o  = (state == REQ);
    assign wb_stb_o  = (state == REQ);
    assign wb_we_o   = 1'b0;
    assign wb_sel_o  = WB_SEL_ALL;
    assign wb_adr_o  = adr;
    assign pix_valid = !fifo_empty;
    assign pix_sof   = !fifo_empty && head.sof;
    assign pix_data  = head.data;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Directed bench for wb_frame_reader with a 4-word frame, 4-deep FIFO and a scripted slave.
module tb_wb_frame_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        flush;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic [31:0] pix_data;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic        err_flag;

    int n_err = 0;
    int n_chk = 0;

    logic [32:0] stream_q [$];
    logic [31:0] adr_log  [$];
    logic [31:0] bram [4];
    logic        hold, rty_arm, err_arm, gap_cyc;
    logic [31:0] hold_adr, rty_adr, err_adr;
    int          n_resp;

    wb_frame_reader #(
        .ADR_W       (32),
        .BASE_ADR    (32'h0),
        .FRAME_WORDS (4),
        .ADR_STEP    (4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .flush     (flush),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_sel_o  (wb_sel_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i),
        .wb_rty_i  (wb_rty_i),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .err_flag  (err_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave answers one cycle after it sees a strobe; monitor logs accepted pixels.
    always @(negedge clk) begin
        if (wb_ack_i || wb_err_i || wb_rty_i) begin
            if (wb_rty_i) gap_cyc = wb_cyc_o;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
        end else if (wb_cyc_o && wb_stb_o && !(hold && wb_adr_o == hold_adr)) begin
            adr_log.push_back(wb_adr_o);
            n_resp++;
            if (rty_arm && wb_adr_o == rty_adr) begin
                rty_arm  = 1'b0;
                wb_rty_i = 1'b1;
            end else if (err_arm && wb_adr_o == err_adr) begin
                err_arm  = 1'b0;
                wb_err_i = 1'b1;
                wb_dat_i = 32'hDEAD_BEEF;
            end else begin
                wb_ack_i = 1'b1;
                wb_dat_i = bram[wb_adr_o[3:2]];
            end
        end
        if (pix_valid && pix_ready) stream_q.push_back({pix_sof, pix_data});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input string tag, input int n);
        int k = 0;
        while (stream_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        check(tag, 64'(stream_q.size() >= n), 64'd1);
    endtask

    task automatic check_word(input string tag, input int i, input logic sof, input logic [31:0] d);
        logic [32:0] v;
        v = '1;
        if (i < stream_q.size()) v = stream_q[i];
        check(tag, 64'(v), 64'({sof, d}));
    endtask

    task automatic check_adr(input string tag, input int i, input logic [31:0] a);
        logic [31:0] v;
        v = '1;
        if (i < adr_log.size()) v = adr_log[i];
        check(tag, 64'(v), 64'(a));
    endtask

    task automatic idle_wait(input string tag);
        int k = 0;
        enable = 1'b0;
        while (wb_cyc_o && k < 50) begin
            tick();
            k++;
        end
        check(tag, 64'(wb_cyc_o), 64'd0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        stream_q.delete();
        adr_log.delete();
    endtask

    initial begin
        int base;
        int k;
        bram[0] = 32'h10; bram[1] = 32'h11; bram[2] = 32'h12; bram[3] = 32'h13;
        rst_n = 1'b0; enable = 1'b0; flush = 1'b0; pix_ready = 1'b0;
        wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
        hold = 1'b0; rty_arm = 1'b0; err_arm = 1'b0; gap_cyc = 1'b1;
        hold_adr = '0; rty_adr = '0; err_adr = '0; n_resp = 0;

        // Reset state
        repeat (3) tick();
        check("rst_cyc",   64'(wb_cyc_o),  64'd0);
        check("rst_stb",   64'(wb_stb_o),  64'd0);
        check("rst_adr",   64'(wb_adr_o),  64'd0);
        check("rst_valid", 64'(pix_valid), 64'd0);
        check("rst_sof",   64'(pix_sof),   64'd0);
        check("rst_err",   64'(err_flag),  64'd0);
        check("rst_we",    64'(wb_we_o),   64'd0);
        check("rst_sel",   64'(wb_sel_o),  64'hF);
        rst_n = 1'b1;
        tick();

        // Sequential read with wrap
        pix_ready = 1'b1;
        enable = 1'b1;
        collect("t2_len", 6);
        check_word("t2_w0", 0, 1'b1, 32'h10);
        check_word("t2_w1", 1, 1'b0, 32'h11);
        check_word("t2_w2", 2, 1'b0, 32'h12);
        check_word("t2_w3", 3, 1'b0, 32'h13);
        check_word("t2_w4", 4, 1'b1, 32'h10);
        check_word("t2_w5", 5, 1'b0, 32'h11);
        check_adr("t2_a0", 0, 32'h0);
        check_adr("t2_a1", 1, 32'h4);
        check_adr("t2_a2", 2, 32'h8);
        check_adr("t2_a3", 3, 32'hC);
        check_adr("t2_a4", 4, 32'h0);
        idle_wait("t2_idle");
        pulse_flush();

        // Backpressure fills FIFO exactly
        pix_ready = 1'b0;
        base = n_resp;
        enable = 1'b1;
        repeat (40) tick();
        check("t3_fetched", 64'(n_resp - base), 64'd4);
        check("t3_cyc",     64'(wb_cyc_o),      64'd0);
        check("t3_valid",   64'(pix_valid),     64'd1);
        check("t3_head",    64'({pix_sof, pix_data}), 64'({1'b1, 32'h10}));
        pix_ready = 1'b1;
        collect("t3_len", 5);
        check_word("t3_w0", 0, 1'b1, 32'h10);
        check_word("t3_w3", 3, 1'b0, 32'h13);
        check_word("t3_w4", 4, 1'b1, 32'h10);
        idle_wait("t3_idle");
        pulse_flush();

        // Retry at address 8
        rty_adr = 32'h8;
        rty_arm = 1'b1;
        gap_cyc = 1'b1;
        enable = 1'b1;
        collect("t4_len", 5);
        check_adr("t4_a2", 2, 32'h8);
        check_adr("t4_a3", 3, 32'h8);
        check_adr("t4_a4", 4, 32'hC);
        check("t4_gap_cyc", 64'(gap_cyc), 64'd0);
        check_word("t4_w1", 1, 1'b0, 32'h11);
        check_word("t4_w2", 2, 1'b0, 32'h12);
        check_word("t4_w3", 3, 1'b0, 32'h13);
        check_word("t4_w4", 4, 1'b1, 32'h10);
        idle_wait("t4_idle");
        pulse_flush();

        // Error at address 4
        err_adr = 32'h4;
        err_arm = 1'b1;
        enable = 1'b1;
        collect("t5_len", 5);
        check_word("t5_w0", 0, 1'b1, 32'h10);
        check_word("t5_w1", 1, 1'b0, 32'h0);
        check_word("t5_w2", 2, 1'b0, 32'h12);
        check_word("t5_w4", 4, 1'b1, 32'h10);
        idle_wait("t5_idle");
        check("t5_err_sticky", 64'(err_flag), 64'd1);
        pulse_flush();
        check("t5_err_clr", 64'(err_flag), 64'd0);

        // Flush while ack pending at address C
        pix_ready = 1'b0;
        hold_adr = 32'hC;
        hold = 1'b1;
        enable = 1'b1;
        k = 0;
        while (!(wb_cyc_o && wb_adr_o == 32'hC) && k < 100) begin
            tick();
            k++;
        end
        repeat (3) tick();
        check("t6_stall_cyc", 64'(wb_cyc_o), 64'd1);
        check("t6_stall_adr", 64'(wb_adr_o), 64'hC);
        check("t6_pre_valid", 64'(pix_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        hold = 1'b0;
        base = n_resp;
        k = 0;
        while (n_resp == base && k < 50) begin
            tick();
            k++;
        end
        check("t6_valid", 64'(pix_valid), 64'd0);
        check("t6_cyc",   64'(wb_cyc_o),  64'd0);
        pix_ready = 1'b1;
        collect("t6_len", 2);
        check_word("t6_w0", 0, 1'b1, 32'h10);
        check_word("t6_w1", 1, 1'b0, 32'h11);
        check_adr("t6_a3", 3, 32'hC);
        check_adr("t6_a4", 4, 32'h0);
        idle_wait("t6_idle");
        pulse_flush();

        // Asynchronous reset in the middle of a transaction
        hold_adr = 32'h0;
        hold = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        check("t1_pre_cyc", 64'(wb_cyc_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t1_cyc",   64'(wb_cyc_o),  64'd0);
        check("t1_stb",   64'(wb_stb_o),  64'd0);
        check("t1_adr",   64'(wb_adr_o),  64'd0);
        check("t1_valid", 64'(pix_valid), 64'd0);
        enable = 1'b0;
        hold = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
